// File: rtl/sqrt_ctrl_pkg.sv
// Shared types and FP16 constants for the sqrt2 sharing controller.
package sqrt_ctrl_pkg;

    localparam int FP16_W = 16;

    localparam logic [FP16_W-1:0] FP16_QNAN    = 16'h7E00;
    localparam logic [FP16_W-1:0] FP16_NEG_NAN = 16'hFE00;
    localparam logic [FP16_W-1:0] FP16_PINF    = 16'h7C00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/sqrt_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set REQ bit at or after PTR, wrapping.
module rr_arbiter
    import sqrt_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [IDX_W-1:0]   PTR,
    output logic [NUM_REQ-1:0] GRANT,
    output logic [IDX_W-1:0]   WINNER,
    output logic               VALID
);

    int idx;

    always_comb begin
        GRANT  = '0;
        WINNER = '0;
        VALID  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(PTR) + i) % NUM_REQ;
            if (!VALID && REQ[idx]) begin
                VALID       = 1'b1;
                WINNER      = IDX_W'(idx);
                GRANT[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_share_ctrl.sv
// Shares one sqrt2 FP16 square-root unit among NUM_REQ requesters (round-robin).
// Optional watchdog abort in WAIT is enabled with `define SQRT_TIMEOUT_EN.
module sqrt_share_ctrl
    import sqrt_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 31
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [FP16_W*NUM_REQ-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]        GRANT,
    output logic [NUM_REQ-1:0]        RSP_VALID,
    output logic [FP16_W-1:0]         RSP_DATA,
    output logic                      RSP_NAN,
    output logic                      RSP_PINF,
    output logic                      RSP_NINF,
    output logic                      RSP_TIMEOUT,
    output logic                      BUSY,
    inout  wire  [FP16_W-1:0]         SQRT_IO,
    output logic                      SQRT_ENABLE,
    input  logic                      SQRT_RESULT,
    input  logic                      SQRT_IS_NAN,
    input  logic                      SQRT_IS_PINF,
    input  logic                      SQRT_IS_NINF,
    output logic [1:0]                STATE_DBG
);

    localparam int IDX_W = $clog2(NUM_REQ);

    ctrl_state_t         state;
    logic [IDX_W-1:0]    ptr;
    logic [NUM_REQ-1:0]  owner_q;
    logic [FP16_W-1:0]   op_q;
    logic                io_oe;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_winner;
    logic                arb_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .REQ    (REQ),
        .PTR    (ptr),
        .GRANT  (arb_grant),
        .WINNER (arb_winner),
        .VALID  (arb_valid)
    );

    // Bus handshake: we own SQRT_IO only during ISSUE; the unit drives it from
    // its 2nd enabled edge, so there is always one idle cycle between owners.
    assign SQRT_IO   = io_oe ? op_q : {FP16_W{1'bz}};
    assign STATE_DBG = state;

`ifdef SQRT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    // Constant 0; the expression only keeps the parameter referenced.
    assign RSP_TIMEOUT = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            ptr         <= '0;
            owner_q     <= '0;
            op_q        <= '0;
            io_oe       <= 1'b0;
            SQRT_ENABLE <= 1'b0;
            GRANT       <= '0;
            RSP_VALID   <= '0;
            RSP_DATA    <= '0;
            RSP_NAN     <= 1'b0;
            RSP_PINF    <= 1'b0;
            RSP_NINF    <= 1'b0;
            BUSY        <= 1'b0;
`ifdef SQRT_TIMEOUT_EN
            wd_cnt      <= '0;
            RSP_TIMEOUT <= 1'b0;
`endif
        end else begin
            GRANT     <= '0;
            RSP_VALID <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        op_q        <= REQ_DATA[FP16_W*int'(arb_winner) +: FP16_W];
                        GRANT       <= arb_grant;
                        owner_q     <= arb_grant;
                        ptr         <= (arb_winner == IDX_W'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;
                        io_oe       <= 1'b1;
                        SQRT_ENABLE <= 1'b1;
                        BUSY        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    io_oe <= 1'b0;
                    state <= WAIT;
`ifdef SQRT_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (SQRT_RESULT) begin
                        RSP_DATA    <= SQRT_IO;
                        RSP_NAN     <= SQRT_IS_NAN;
                        RSP_PINF    <= SQRT_IS_PINF;
                        RSP_NINF    <= SQRT_IS_NINF;
                        RSP_VALID   <= owner_q;
                        SQRT_ENABLE <= 1'b0;
                        state       <= DONE;
`ifdef SQRT_TIMEOUT_EN
                        RSP_TIMEOUT <= 1'b0;
                    end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES)) begin
                        RSP_DATA    <= FP16_QNAN;
                        RSP_NAN     <= 1'b1;
                        RSP_PINF    <= 1'b0;
                        RSP_NINF    <= 1'b0;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_VALID   <= owner_q;
                        SQRT_ENABLE <= 1'b0;
                        state       <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Directed bench for sqrt_share_ctrl with a behavioural sqrt2 unit on the shared bus.
`timescale 1ns/1ps
module tb_sqrt_share_ctrl;
    import sqrt_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int TO = 20;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [N-1:0]      REQ;
    logic [16*N-1:0]   REQ_DATA;
    logic [N-1:0]      GRANT, RSP_VALID;
    logic [15:0]       RSP_DATA;
    logic              RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT, BUSY;
    wire  [15:0]       SQRT_IO;
    logic              SQRT_ENABLE;
    logic              SQRT_RESULT, SQRT_IS_NAN, SQRT_IS_PINF, SQRT_IS_NINF;
    logic [1:0]        STATE_DBG;

    sqrt_share_ctrl #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_DATA(REQ_DATA),
        .GRANT(GRANT), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
        .RSP_NAN(RSP_NAN), .RSP_PINF(RSP_PINF), .RSP_NINF(RSP_NINF),
        .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY), .SQRT_IO(SQRT_IO),
        .SQRT_ENABLE(SQRT_ENABLE), .SQRT_RESULT(SQRT_RESULT),
        .SQRT_IS_NAN(SQRT_IS_NAN), .SQRT_IS_PINF(SQRT_IS_PINF),
        .SQRT_IS_NINF(SQRT_IS_NINF), .STATE_DBG(STATE_DBG)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- sqrt2 unit model ----------------
    function automatic logic [18:0] sqrt_ref(input logic [15:0] x);  // {nan,pinf,ninf,result}
        if (x[14:10] == 5'h1F && x[9:0] != 10'd0) return {3'b100, x | 16'h0200};
        if (x == FP16_PINF)                       return {3'b010, FP16_PINF};
        if (x == 16'h8000)                        return {3'b000, 16'h8000};
        if (x[15])                                return {3'b100, FP16_NEG_NAN};
        case (x)
            16'h4400: return {3'b000, 16'h4000};
            16'h4C00: return {3'b000, 16'h4400};
            16'h3C00: return {3'b000, 16'h3C00};
            default:  return {3'b000, 16'h0000};
        endcase
    endfunction

    function automatic logic is_short(input logic [15:0] x);
        return (x == 16'h8000) || (x[14:10] == 5'h1F && (x[9:0] != 10'd0 || !x[15]));
    endfunction

    logic        model_oe = 1'b0;
    logic [15:0] model_dq = '0;
    logic [15:0] model_op = '0;
    logic        model_stall = 1'b0;
    int          model_cnt = 0;
    logic [18:0] model_r;
    int          bus_bad = 0;

    assign SQRT_IO = model_oe ? model_dq : 16'hzzzz;

    initial begin
        SQRT_RESULT = 1'b0; SQRT_IS_NAN = 1'b0; SQRT_IS_PINF = 1'b0; SQRT_IS_NINF = 1'b0;
    end

    always @(posedge CLK) begin
        if (!SQRT_ENABLE) begin
            model_cnt   <= 0;
            model_oe    <= 1'b0;
            SQRT_RESULT <= 1'b0;
        end else begin
            model_cnt <= model_cnt + 1;
            if (model_cnt == 0) begin
                if ($isunknown(SQRT_IO)) bus_bad <= bus_bad + 1;
                model_op <= SQRT_IO;
            end
            if (model_cnt == 1) begin
                model_r       = sqrt_ref(model_op);
                model_oe     <= 1'b1;
                model_dq     <= model_r[15:0];
                SQRT_IS_NAN  <= model_r[18];
                SQRT_IS_PINF <= model_r[17];
                SQRT_IS_NINF <= model_r[16];
                if (is_short(model_op) && !model_stall) SQRT_RESULT <= 1'b1;
            end
            if (model_cnt == 11 && !is_short(model_op) && !model_stall) SQRT_RESULT <= 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] exp_d;
    int rsp_count    = 0;
    int en_low_run   = 0;
    int min_gap      = 1000;
    bit en_seen_high = 0;

    always @(negedge CLK) begin
        if (model_oe && SQRT_IO !== model_dq) bus_bad++;
        if (!model_oe && $isunknown(SQRT_IO) && SQRT_IO !== 16'hzzzz) bus_bad++;
        if (SQRT_ENABLE) begin
            if (en_seen_high && en_low_run > 0 && en_low_run < min_gap) min_gap = en_low_run;
            en_seen_high = 1;
            en_low_run   = 0;
        end else begin
            en_low_run++;
        end
        if (|RSP_VALID) begin
            rsp_count++;
            exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
            check_eq("sb_rsp_data", RSP_DATA, exp_d);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_grant(output int port, output int gcyc, output bit ok);
        int n = 0;
        ok = 0; port = -1; gcyc = 0;
        while (n < 60) begin
            step();
            n++;
            if (|GRANT) begin
                ok = 1; gcyc = cyc;
                for (int i = 0; i < N; i++) if (GRANT[i]) port = i;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int rcyc, output bit ok);
        int n = 0;
        ok = 0; rcyc = 0;
        while (n < 60) begin
            step();
            n++;
            if (|RSP_VALID) begin
                ok = 1; rcyc = cyc;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input int port, input logic [15:0] op,
                          input logic [15:0] exp_data, input logic e_nan, input logic e_pinf,
                          input logic e_to, input int lat);
        int p, gc, rc;
        bit ok;
        REQ_DATA[16*port +: 16] = op;
        REQ[port] = 1'b1;
        wait_grant(p, gc, ok);
        check_eq({tag, "_grant_seen"}, ok, 1);
        if (!ok) begin
            REQ[port] = 1'b0;
            return;
        end
        check_eq({tag, "_grant"}, GRANT, 32'd1 << port);
        REQ[port] = 1'b0;
        exp_q.push_back(exp_data);
        wait_rsp(rc, ok);
        check_eq({tag, "_rsp_seen"}, ok, 1);
        if (!ok) return;
        check_eq({tag, "_latency"}, rc - gc, lat);
        check_eq({tag, "_rsp_valid"}, RSP_VALID, 32'd1 << port);
        check_eq({tag, "_flags"}, {RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT},
                 {e_nan, e_pinf, 1'b0, e_to});
        step();
        check_eq({tag, "_rsp_pulse"}, RSP_VALID, 0);
    endtask

    // ---------------- directed sequence ----------------
    int p, gc, prev_gc, rc, cnt_before, n;
    bit ok;

    initial begin
        RESET    = 1'b1;
        REQ      = '1;
        REQ_DATA = {N{16'h4400}};
        repeat (3) step();

        check_eq("rst_grant", GRANT, 0);
        check_eq("rst_rsp_valid", RSP_VALID, 0);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_enable", SQRT_ENABLE, 0);
        check_eq("rst_state", STATE_DBG, 0);
        check_eq("rst_rsp_data", {RSP_DATA, RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT}, 0);
        check_eq("rst_bus_z", (SQRT_IO === 16'hzzzz), 1);

        // All requesters held high from reset: fair rotation, 15-cycle spacing.
        RESET   = 1'b0;
        prev_gc = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(p, gc, ok);
            check_eq("rr_grant_seen", ok, 1);
            check_eq("rr_order", p, k % N);
            if (k > 0) check_eq("rr_spacing", gc - prev_gc, 15);
            prev_gc = gc;
            exp_q.push_back(16'h4000);
            if (k == 0) check_eq("rr_busy", BUSY, 1);
        end
        REQ = '0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin step(); n++; end
        check_eq("rr_drain", exp_q.size(), 0);
        check_eq("rr_bus_conflict", bus_bad, 0);
        check_eq("rr_enable_gap", min_gap, 2);
        repeat (3) step();
        check_eq("idle_busy", BUSY, 0);

        run_op("sqrt4",  0, 16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, 13);
        run_op("pinf",   1, 16'h7C00, 16'h7C00, 1'b0, 1'b1, 1'b0, 3);
        run_op("neg2",   2, 16'hC000, 16'hFE00, 1'b1, 1'b0, 1'b0, 13);
        run_op("negz",   0, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 3);
        run_op("nanpay", 1, 16'h7D01, 16'h7F01, 1'b1, 1'b0, 1'b0, 3);

        // Reset while the unit is computing: operation dropped, enable falls at once.
        REQ_DATA[16*2 +: 16] = 16'h4400;
        REQ[2] = 1'b1;
        wait_grant(p, gc, ok);
        check_eq("rst_mid_grant", p, 2);
        REQ[2] = 1'b0;
        repeat (6) step();
        cnt_before = rsp_count;
        RESET = 1'b1;
        #1;
        check_eq("rst_mid_enable", SQRT_ENABLE, 0);
        check_eq("rst_mid_busy", BUSY, 0);
        check_eq("rst_mid_state", STATE_DBG, 0);
        repeat (2) step();
        RESET = 1'b0;
        repeat (20) step();
        check_eq("rst_mid_no_rsp", rsp_count, cnt_before);
        run_op("after_rst", 3, 16'h4C00, 16'h4400, 1'b0, 1'b0, 1'b0, 13);

`ifdef SQRT_TIMEOUT_EN
        model_stall = 1'b1;
        run_op("timeout", 1, 16'h4400, FP16_QNAN, 1'b1, 1'b0, 1'b1, TO + 2);
        model_stall = 1'b0;
        run_op("post_to", 2, 16'h3C00, 16'h3C00, 1'b0, 1'b0, 1'b0, 13);
`endif

        repeat (3) step();
        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("bus_conflict", bus_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/sqrt_share_ctrl.md
Name: sqrt_share_ctrl

Overview:
Arbiter and sequencer that shares one sqrt2 half-precision square-root unit among NUM_REQ requesters.
- Grants requesters round-robin and latches the winner's FP16 operand.
- Drives the unit's shared bidirectional data bus and ENABLE through the sqrt2 issue/compute/release protocol.
- Captures the result word and flags, then returns them to the winner as a one-cycle response.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 31, watchdog limit in cycles; used only with SQRT_TIMEOUT_EN

Ports:
CLK  input  1  clock; all logic on rising edge
RESET  input  1  asynchronous, active-high reset
REQ  input  NUM_REQ  per-requester request level
REQ_DATA  input  16*NUM_REQ  FP16 operands; requester i uses bits [16*i+15:16*i]
GRANT  output  NUM_REQ  one-hot, one-cycle pulse when operand i is latched
RSP_VALID  output  NUM_REQ  one-hot, one-cycle pulse when the result for requester i is valid
RSP_DATA  output  16  result word, valid while any RSP_VALID bit is high
RSP_NAN  output  1  captured IS_NAN
RSP_PINF  output  1  captured IS_PINF
RSP_NINF  output  1  captured IS_NINF
RSP_TIMEOUT  output  1  watchdog abort flag (tied 0 without the macro)
BUSY  output  1  high in every state except IDLE
SQRT_IO  inout  16  to sqrt2 IO_DATA
SQRT_ENABLE  output  1  to sqrt2 ENABLE
SQRT_RESULT  input  1  from sqrt2 RESULT
SQRT_IS_NAN, SQRT_IS_PINF, SQRT_IS_NINF  input  1 each  from sqrt2 flags

Behaviour:
- Clocking and reset: one clock CLK; RESET is asynchronous and active-high.
- While RESET is high, all of the following hold:
  - state = IDLE; round-robin pointer = 0.
  - GRANT, RSP_VALID, RSP_* and BUSY = 0; SQRT_ENABLE = 0.
  - SQRT_IO is high-Z.
- Registered outputs: all outputs are registered; SQRT_IO is driven from a registered enable.
- IDLE:
  - If any REQ bit is high, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that requester's REQ_DATA slice, pulse its GRANT bit, set pointer = winner+1 (wraps), go to ISSUE.
  - A requester may drop REQ after its GRANT pulse. Holding REQ high re-requests; the holder loses priority to the others.
- ISSUE (1 cycle): SQRT_ENABLE = 1; SQRT_IO drives the latched operand. The unit samples the operand at the closing edge. Go to WAIT.
- WAIT:
  - SQRT_ENABLE = 1; SQRT_IO high-Z. The unit drives the bus from its 2nd enabled edge onward.
  - On the edge where SQRT_RESULT = 1 is sampled: capture SQRT_IO into RSP_DATA and the three flags into RSP_NAN/RSP_PINF/RSP_NINF, then go to DONE.
- DONE (1 cycle): SQRT_ENABLE = 0, which resets the unit on its falling edge. RSP_VALID[winner] = 1 with the captured data. Go to IDLE.
- Bus ownership: the controller drives SQRT_IO only in ISSUE. There is never a cycle where both sides drive.
- Latency from the cycle GRANT is high to the cycle RSP_VALID is high:
  - 13 cycles for ordinary operands, including +0, negatives and subnormals.
  - 3 cycles when the unit short-cuts: NaN, +inf, -0.
- Throughput: SQRT_ENABLE is low for at least 2 cycles (DONE + IDLE) between operations. Back-to-back ordinary operations repeat every 15 cycles.
- Requests arriving while BUSY are ignored until IDLE; REQ is level-held, so nothing is lost.
- The controller does not alter result data; NaN payloads and 0xFE00 for negatives pass through.
- RESET mid-operation: the operation is dropped with no RSP_VALID, and SQRT_ENABLE falls immediately, which resets the unit.

Optional Feature:
Macro SQRT_TIMEOUT_EN.
- With the macro: a watchdog counter clears on ISSUE and counts in WAIT.
  - If it reaches TIMEOUT_CYCLES without SQRT_RESULT, go to DONE with RSP_DATA = 16'h7E00, RSP_NAN = 1 and RSP_TIMEOUT = 1.
  - RSP_TIMEOUT is valid with RSP_VALID.
- Without the macro: WAIT waits indefinitely; RSP_TIMEOUT is constant 0; no counter logic is present.

Decomposition:
- Package sqrt_ctrl_pkg:
  - state enum IDLE/ISSUE/WAIT/DONE
  - FP16_QNAN = 16'h7E00, FP16_NEG_NAN = 16'hFE00, FP16_PINF = 16'h7C00
  - FP16_W = 16
- One sub-module, rr_arbiter: a combinational round-robin pick from REQ and the pointer, returning a one-hot grant and the winner index.

Test Plan:
- Port 0 REQ with 0x4400 (4.0) -> GRANT[0] pulse; RSP_VALID[0] 13 cycles later; RSP_DATA = 0x4000; all flags 0.
- Port 1 REQ with 0x7C00 -> RSP_VALID[1] after 3 cycles; RSP_DATA = 0x7C00; RSP_PINF = 1.
- Port 2 REQ with 0xC000 (-2.0) -> RSP_DATA = 0xFE00; RSP_NAN = 1; latency 13.
- All 4 REQs held high from reset with 0x4400 operands -> grant order 0,1,2,3,0; GRANT pulses 15 cycles apart; SQRT_IO never driven by both sides (bench X-check); SQRT_ENABLE low for at least 2 cycles between operations.
- RESET pulsed 5 cycles into WAIT -> SQRT_ENABLE = 0 at once; no RSP_VALID; next REQ on port 3 wins (pointer = 0, only requester) and returns the correct result.
- With SQRT_TIMEOUT_EN, TIMEOUT_CYCLES = 20 and a stub holding SQRT_RESULT = 0 -> RSP_VALID 22 cycles after GRANT; RSP_DATA = 0x7E00; RSP_TIMEOUT = 1.
